// File: rtl/codecheck.sv
// Checker for a saturating incrementing code-word generator: counts samples and mismatches,
// captures the first mismatch, and flags a clean pass once the sequence saturates.
module codecheck #(
    parameter int unsigned W  = 16,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_h,
    input  logic          vld,
    input  logic [W-1:0]  data,
    input  logic          clr,
    output logic [1:0]    state,
    output logic          err,
    output logic          pass,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [W-1:0]  first_exp,
    output logic [W-1:0]  first_got
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StSat  = 2'd2
    } st_e;

    localparam logic [W-1:0]  ExpMax = '1;
    localparam logic [CW-1:0] CntMax = '1;

    st_e           st_q, st_d;
    logic [W-1:0]  exp_q, exp_d;
    logic [CW-1:0] wc_q, wc_d;
    logic [CW-1:0] ec_q, ec_d;
    logic          err_q, err_d;
    logic [W-1:0]  fe_q, fe_d;
    logic [W-1:0]  fg_q, fg_d;
    logic          mismatch;

    assign mismatch = (data != exp_q);

    always_comb begin
        st_d  = st_q;
        exp_d = exp_q;
        wc_d  = wc_q;
        ec_d  = ec_q;
        err_d = err_q;
        fe_d  = fe_q;
        fg_d  = fg_q;
        if (clr) begin
            // Clear takes priority; any sample on the same edge is dropped.
            st_d  = StIdle;
            exp_d = '0;
            wc_d  = '0;
            ec_d  = '0;
            err_d = 1'b0;
            fe_d  = '0;
            fg_d  = '0;
        end else if (vld) begin
            exp_d = (exp_q == ExpMax) ? exp_q : exp_q + 1'b1;
            wc_d  = (wc_q == CntMax) ? wc_q : wc_q + 1'b1;
            if (mismatch) begin
                ec_d  = (ec_q == CntMax) ? ec_q : ec_q + 1'b1;
                err_d = 1'b1;
                if (!err_q) begin
                    fe_d = exp_q;
                    fg_d = data;
                end
            end
            unique case (st_q)
                StIdle:  st_d = (exp_q == ExpMax) ? StSat : StRun;
                StRun:   st_d = (exp_q == ExpMax) ? StSat : StRun;
                StSat:   st_d = StSat;
                default: st_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            st_q  <= StIdle;
            exp_q <= '0;
            wc_q  <= '0;
            ec_q  <= '0;
            err_q <= 1'b0;
            fe_q  <= '0;
            fg_q  <= '0;
        end else begin
            st_q  <= st_d;
            exp_q <= exp_d;
            wc_q  <= wc_d;
            ec_q  <= ec_d;
            err_q <= err_d;
            fe_q  <= fe_d;
            fg_q  <= fg_d;
        end
    end

    assign state     = st_q;
    assign err       = err_q;
    assign pass      = (st_q == StSat) && (ec_q == '0);
    assign word_cnt  = wc_q;
    assign err_cnt   = ec_q;
    assign first_exp = fe_q;
    assign first_got = fg_q;

endmodule

// File: doc/codecheck.md
CODECHECK -- requirements
Module: codecheck

Interface
REQ-001 Parameter W, default 16, data word width.
REQ-002 Parameter CW, default 16, width of word and error counters.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_h  input  1  reset, asynchronous, active-high.
REQ-005 vld  input  1  sample strobe; data is sampled on a clock edge where vld=1.
REQ-006 data  input  W  incoming code word from the saturating incrementing generator.
REQ-007 clr  input  1  synchronous clear of all checker state, active-high.
REQ-008 state  output  2  FSM state: 0=IDLE, 1=RUN, 2=SAT; 3 is unused.
REQ-009 err  output  1  sticky mismatch flag.
REQ-010 pass  output  1  high when state=SAT and err_cnt=0.
REQ-011 word_cnt  output  CW  number of samples taken, saturating.
REQ-012 err_cnt  output  CW  number of mismatching samples, saturating.
REQ-013 first_exp  output  W  expected value at the first mismatch.
REQ-014 first_got  output  W  received value at the first mismatch.

Function
REQ-015 Internal register exp (W bits) SHALL hold the expected next word, starting at 0.
REQ-016 Each sample SHALL compare data with exp; mismatch = data != exp.
REQ-017 After each sample, exp SHALL advance to exp+1, saturating at all-ones, independent of match result (no resync to data).
REQ-018 Each sample SHALL increment word_cnt, holding at all-ones.
REQ-019 On mismatch, err_cnt SHALL increment (holding at all-ones), and err SHALL set and stay set.
REQ-020 On the first mismatch only (err=0 before the edge), first_exp and first_got SHALL latch exp and data; later mismatches SHALL leave them unchanged.
REQ-021 All outputs SHALL be registered; the effect of a sample SHALL be visible on outputs one cycle after the sampling edge.
REQ-022 IDLE -> RUN on the first sample.
REQ-023 RUN -> SAT on the sample where exp equals all-ones; that sample is still checked.
REQ-024 In SAT, exp SHALL remain all-ones and every further sample SHALL be checked against all-ones.
REQ-025 SAT SHALL be left only through clr or rst_h.
REQ-026 vld=0 SHALL leave all state unchanged.
REQ-027 clr=1 SHALL return state to IDLE and set exp, counters, err, first_exp and first_got to 0 on that edge.
REQ-028 clr=1 with vld=1 on the same edge: clr SHALL win and the sample SHALL be discarded.
REQ-029 pass SHALL be derived from registered state and err_cnt and SHALL drop in the cycle after any mismatch in SAT.

Reset
REQ-030 rst_h=1 SHALL immediately and asynchronously force state=IDLE, exp=0, and all outputs to 0.
REQ-031 rst_h asserted mid-run SHALL discard any in-flight sample.
REQ-032 After rst_h deasserts, the first vld edge SHALL be treated as the first sample of a new sequence.

Verification
REQ-033 Scenario 1: reset, then drive vld=1 with data 0..9 -> word_cnt=10, err_cnt=0, err=0, state=RUN, pass=0.
REQ-034 Scenario 2: drive data 0,1,2,7,4 -> err_cnt=1, err=1, first_exp=0x0003, first_got=0x0007; a following 5 SHALL pass with no error.
REQ-035 Scenario 3: drive 0x0000..0xFFFF continuously, then three more 0xFFFF -> state=SAT after sample 65536, word_cnt=0xFFFF (saturated), err_cnt=0, pass=1.
REQ-036 Scenario 4: in SAT, drive data 0x0000 -> err_cnt=1, pass=0 next cycle, first_exp=0xFFFF, first_got=0x0000.
REQ-037 Scenario 5: at word 100 assert clr together with vld carrying 100 -> next cycle state=IDLE, all counters 0; a following 0 is accepted with no error.
REQ-038 Scenario 6: assert rst_h asynchronously mid-RUN between clock edges -> all outputs 0 before the next edge; vld gaps (vld=0 cycles) mid-sequence SHALL cause no errors.
